// File: rtl/sequencer_pattern_editor_if.sv
// Purpose : bundles the pushbutton/switch inputs and editor state outputs of the pattern editor.
// Latency : none, wires only.
// Backpressure: none; buttons are levels and outputs are registered state.
// Ports   : master = stimulus side (drives buttons, reads state); slave = editor side.
interface sequencer_pattern_editor_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_toggle;
    logic       btn_clear;
    logic       btn_up;
    logic       btn_down;
    logic       sel_tempo;
    logic [7:0] pattern;
    logic [7:0] cursor_led;
    logic [3:0] pitch_idx;
    logic [2:0] tempo_idx;
    logic       edit_pulse;

    modport master (
        output btn_left, btn_right, btn_toggle, btn_clear, btn_up, btn_down, sel_tempo,
        input  pattern, cursor_led, pitch_idx, tempo_idx, edit_pulse
    );

    modport slave (
        input  btn_left, btn_right, btn_toggle, btn_clear, btn_up, btn_down, sel_tempo,
        output pattern, cursor_led, pitch_idx, tempo_idx, edit_pulse
    );
endinterface

// File: rtl/sequencer_pattern_editor.sv
// Purpose : debounces six raw pushbuttons and edits an 8-step pattern, cursor, pitch and tempo.
// Latency : a clean press updates outputs DEBOUNCE_CYCLES+3 cycles after the raw rising edge.
// Backpressure: none; simultaneous presses resolve to one action, the rest are dropped.
// Ports   : clk, rst (async, active-high); bus.slave carries buttons, sel_tempo and the
//           registered outputs pattern, cursor_led, pitch_idx, tempo_idx, edit_pulse.
module sequencer_pattern_editor #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    sequencer_pattern_editor_if.slave   bus
);
    localparam int NBTN  = 6;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index doubles as priority order: lower index wins.
    localparam int B_CLEAR  = 0;
    localparam int B_TOGGLE = 1;
    localparam int B_LEFT   = 2;
    localparam int B_RIGHT  = 3;
    localparam int B_UP     = 4;
    localparam int B_DOWN   = 5;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q, sync1_d;
    logic [NBTN-1:0] sync2_q, sync2_d;
    db_state_e       db_state_q [NBTN];
    db_state_e       db_state_d [NBTN];
    logic [CNT_W-1:0] db_cnt_q  [NBTN];
    logic [CNT_W-1:0] db_cnt_d  [NBTN];
    logic [NBTN-1:0] press_pulse;

    logic [7:0] pattern_q, pattern_d;
    logic [7:0] cursor_q, cursor_d;
    logic [3:0] pitch_q, pitch_d;
    logic [2:0] tempo_q, tempo_d;
    logic       edit_q, edit_d;

    assign btn_raw = {bus.btn_down, bus.btn_up, bus.btn_right,
                      bus.btn_left, bus.btn_toggle, bus.btn_clear};

    // Synchronizers and per-button debounce FSMs.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        for (int i = 0; i < NBTN; i++) begin
            db_state_d[i]  = db_state_q[i];
            db_cnt_d[i]    = db_cnt_q[i];
            press_pulse[i] = 1'b0;
            case (db_state_q[i])
                RELEASED: begin
                    if (sync2_q[i]) begin
                        db_state_d[i] = PRESS_WAIT;
                        db_cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        db_state_d[i] = RELEASED;
                    end else if (db_cnt_q[i] == CNT_LAST) begin
                        // Pulse is combinational so the edit lands on the same edge
                        // the FSM enters PRESSED.
                        db_state_d[i]  = PRESSED;
                        press_pulse[i] = 1'b1;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        db_state_d[i] = RELEASE_WAIT;
                        db_cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        db_state_d[i] = PRESSED;
                    end else if (db_cnt_q[i] == CNT_LAST) begin
                        db_state_d[i] = RELEASED;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    db_state_d[i] = RELEASED;
                    db_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Edit datapath: one action per cycle, chosen by fixed priority.
    always_comb begin
        pattern_d = pattern_q;
        cursor_d  = cursor_q;
        pitch_d   = pitch_q;
        tempo_d   = tempo_q;
        edit_d    = |press_pulse;

        if (press_pulse[B_CLEAR]) begin
            pattern_d = 8'h00;
        end else if (press_pulse[B_TOGGLE]) begin
            pattern_d = pattern_q ^ cursor_q;
        end else if (press_pulse[B_LEFT]) begin
            cursor_d = {cursor_q[6:0], cursor_q[7]};
        end else if (press_pulse[B_RIGHT]) begin
            cursor_d = {cursor_q[0], cursor_q[7:1]};
        end else if (press_pulse[B_UP]) begin
            if (bus.sel_tempo) begin
                if (tempo_q != 3'd7) tempo_d = tempo_q + 3'd1;
            end else begin
                if (pitch_q != 4'd15) pitch_d = pitch_q + 4'd1;
            end
        end else if (press_pulse[B_DOWN]) begin
            if (bus.sel_tempo) begin
                if (tempo_q != 3'd0) tempo_d = tempo_q - 3'd1;
            end else begin
                if (pitch_q != 4'd0) pitch_d = pitch_q - 4'd1;
            end
        end

        // Recover from a corrupted cursor: zero or more than one bit set.
        if ((cursor_q == 8'h00) || ((cursor_q & (cursor_q - 8'd1)) != 8'h00)) begin
            cursor_d = 8'h80;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_state_q[i] <= RELEASED;
                db_cnt_q[i]   <= '0;
            end
            pattern_q <= 8'h00;
            cursor_q  <= 8'h80;
            pitch_q   <= 4'd12;
            tempo_q   <= 3'd0;
            edit_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            for (int i = 0; i < NBTN; i++) begin
                db_state_q[i] <= db_state_d[i];
                db_cnt_q[i]   <= db_cnt_d[i];
            end
            pattern_q <= pattern_d;
            cursor_q  <= cursor_d;
            pitch_q   <= pitch_d;
            tempo_q   <= tempo_d;
            edit_q    <= edit_d;
        end
    end

    assign bus.pattern    = pattern_q;
    assign bus.cursor_led = cursor_q;
    assign bus.pitch_idx  = pitch_q;
    assign bus.tempo_idx  = tempo_q;
    assign bus.edit_pulse = edit_q;
endmodule

// File: tb/tb_sequencer_pattern_editor.sv
// Purpose : self-checking bench for sequencer_pattern_editor with a short debounce period.
// Latency : checks the press-to-output delay across a reset release.
// Backpressure: n/a; stimulus is driven one button event at a time.
module tb_sequencer_pattern_editor;
    localparam int DB = 4;

    // Button indices for the stimulus vector.
    localparam int CLR = 0, TOG = 1, LFT = 2, RGT = 3, UPB = 4, DNB = 5;

    logic clk;
    logic rst;
    logic [5:0] btns;
    int total;
    int bad;
    int edit_cnt;

    // Reference model: cursor kept as a step position (0 = first step = bit 7).
    logic [7:0] m_pattern;
    int         m_pos;
    int         m_pitch;
    int         m_tempo;

    sequencer_pattern_editor_if bus ();

    assign bus.btn_clear  = btns[CLR];
    assign bus.btn_toggle = btns[TOG];
    assign bus.btn_left   = btns[LFT];
    assign bus.btn_right  = btns[RGT];
    assign bus.btn_up     = btns[UPB];
    assign bus.btn_down   = btns[DNB];

    sequencer_pattern_editor #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.edit_pulse === 1'b1) edit_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pattern = 8'h00;
        m_pos     = 0;
        m_pitch   = 12;
        m_tempo   = 0;
    endtask

    task automatic model_apply(input int b, input logic sel);
        case (b)
            CLR: m_pattern = 8'h00;
            TOG: m_pattern = m_pattern ^ (8'h80 >> m_pos);
            LFT: m_pos = (m_pos + 7) % 8;
            RGT: m_pos = (m_pos + 1) % 8;
            UPB: if (sel) m_tempo = (m_tempo < 7) ? m_tempo + 1 : 7;
                 else     m_pitch = (m_pitch < 15) ? m_pitch + 1 : 15;
            DNB: if (sel) m_tempo = (m_tempo > 0) ? m_tempo - 1 : 0;
                 else     m_pitch = (m_pitch > 0) ? m_pitch - 1 : 0;
            default: ;
        endcase
    endtask

    // Clean press: hold long enough to debounce, release, let release settle.
    task automatic press(input int b, input int hold);
        btns[b] = 1'b1;
        step(hold);
        btns[b] = 1'b0;
        step(12);
        model_apply(b, bus.sel_tempo);
    endtask

    task automatic check_model(input string tag);
        total++;
        if (bus.pattern !== m_pattern) begin
            bad++;
            $display("FAIL %s pattern: got %h want %h", tag, bus.pattern, m_pattern);
        end
        total++;
        if (bus.cursor_led !== (8'h80 >> m_pos)) begin
            bad++;
            $display("FAIL %s cursor_led: got %h want %h", tag, bus.cursor_led, 8'h80 >> m_pos);
        end
        total++;
        if (bus.pitch_idx !== 4'(m_pitch)) begin
            bad++;
            $display("FAIL %s pitch_idx: got %0d want %0d", tag, bus.pitch_idx, m_pitch);
        end
        total++;
        if (bus.tempo_idx !== 3'(m_tempo)) begin
            bad++;
            $display("FAIL %s tempo_idx: got %0d want %0d", tag, bus.tempo_idx, m_tempo);
        end
    endtask

    task automatic check_edits(input string tag, input int start, input int want);
        total++;
        if (edit_cnt - start !== want) begin
            bad++;
            $display("FAIL %s edit_pulse count: got %0d want %0d", tag, edit_cnt - start, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        model_reset();
        check_model("in_reset");
        total++;
        if (bus.edit_pulse !== 1'b0) begin
            bad++;
            $display("FAIL in_reset edit_pulse: got %b want 0", bus.edit_pulse);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int s;
        s = edit_cnt;
        step(20);
        check_model("idle");
        check_edits("idle", s, 0);
    endtask

    task automatic test_edit_sequence();
        int s;
        s = edit_cnt;
        for (int i = 0; i < 3; i++) press(RGT, 10);
        press(TOG, 10);
        for (int i = 0; i < 3; i++) press(LFT, 10);
        press(TOG, 10);
        check_model("edit_seq");
        total++;
        if (bus.pattern !== 8'h90 || bus.cursor_led !== 8'h80) begin
            bad++;
            $display("FAIL edit_seq literal: got pattern %h cursor %h want 90 80",
                     bus.pattern, bus.cursor_led);
        end
        check_edits("edit_seq", s, 8);
    endtask

    task automatic test_bounce();
        int s;
        press(CLR, 10);
        s = edit_cnt;
        for (int i = 0; i < 3; i++) begin
            btns[TOG] = 1'b1;
            step(2);
            btns[TOG] = 1'b0;
            step(2);
        end
        btns[TOG] = 1'b1;
        step(10);
        btns[TOG] = 1'b0;
        step(12);
        model_apply(TOG, 1'b0);
        check_model("bounce");
        total++;
        if (bus.pattern !== 8'h80) begin
            bad++;
            $display("FAIL bounce pattern literal: got %h want 80", bus.pattern);
        end
        check_edits("bounce", s, 1);
    endtask

    task automatic test_saturation();
        int s;
        bus.sel_tempo = 1'b1;
        s = edit_cnt;
        for (int i = 0; i < 9; i++) press(UPB, 9);
        check_model("tempo_sat");
        total++;
        if (bus.tempo_idx !== 3'd7) begin
            bad++;
            $display("FAIL tempo_sat literal: got %0d want 7", bus.tempo_idx);
        end
        check_edits("tempo_sat", s, 9);
        bus.sel_tempo = 1'b0;
        s = edit_cnt;
        for (int i = 0; i < 14; i++) press(DNB, 9);
        check_model("pitch_sat");
        total++;
        if (bus.pitch_idx !== 4'd0) begin
            bad++;
            $display("FAIL pitch_sat literal: got %0d want 0", bus.pitch_idx);
        end
        check_edits("pitch_sat", s, 14);
    endtask

    task automatic test_simultaneous();
        int s;
        press(CLR, 10);
        for (int i = 0; i < 8; i++) begin
            press(TOG, 10);
            press(RGT, 10);
        end
        check_model("fill_ff");
        s = edit_cnt;
        btns[CLR] = 1'b1;
        btns[TOG] = 1'b1;
        step(10);
        btns[CLR] = 1'b0;
        btns[TOG] = 1'b0;
        step(12);
        model_apply(CLR, 1'b0);
        check_model("clear_vs_toggle");
        check_edits("clear_vs_toggle", s, 1);
    endtask

    task automatic test_reset_mid_press();
        btns[RGT] = 1'b1;
        step(5);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
        step(DB + 2);
        total++;
        if (bus.cursor_led !== 8'h80) begin
            bad++;
            $display("FAIL rst_mid_press early cursor: got %h want 80", bus.cursor_led);
        end
        step(1);
        model_apply(RGT, 1'b0);
        total++;
        if (bus.cursor_led !== 8'h40) begin
            bad++;
            $display("FAIL rst_mid_press latency cursor: got %h want 40", bus.cursor_led);
        end
        btns[RGT] = 1'b0;
        step(12);
        check_model("rst_mid_press");
    endtask

    task automatic test_random();
        int s, b, hold;
        for (int n = 0; n < 30; n++) begin
            b    = $urandom_range(0, 5);
            hold = $urandom_range(9, 25);
            bus.sel_tempo = 1'($urandom_range(0, 1));
            s = edit_cnt;
            press(b, hold);
            check_model("random");
            check_edits("random", s, 1);
        end
    endtask

    task automatic test_random_bounce();
        int s, b;
        s = edit_cnt;
        for (int n = 0; n < 12; n++) begin
            b = $urandom_range(0, 5);
            for (int k = 0; k < 3; k++) begin
                btns[b] = 1'b1;
                step($urandom_range(1, DB - 1));
                btns[b] = 1'b0;
                step($urandom_range(1, 3));
            end
            step(10);
        end
        check_model("random_bounce");
        check_edits("random_bounce", s, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        edit_cnt = 0;
        btns = '0;
        bus.sel_tempo = 1'b0;
        rst = 1'b1;
        model_reset();
        test_reset();
        test_idle();
        test_edit_sequence();
        test_bounce();
        test_saturation();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        test_random_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
